rsa_modexp_scheduler: RTL and testbench

//  Shares one RSA modular-exponentiation engine between NUM_REQ requesters, e.g. host key

---
 rtl/rsa_sched_pkg.sv | 27 ++
 rtl/rsa_rr_arbiter.sv | 46 ++++
 rtl/rsa_modexp_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_rsa_modexp_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_sched_pkg.sv
// ----------------------------------------------------------------------------
// rsa_sched_pkg
// Shared types and constants for the RSA modular-exponentiation scheduler.
//   state_t          : scheduler FSM states
//   id_w()           : requester-index width for a given requester count
//   ENG_MIN_LATENCY  : shortest start->done latency a conforming engine shows
//   ENG_MAX_LATENCY  : longest start->done latency checkers should tolerate
// ----------------------------------------------------------------------------
package rsa_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP,
        S_ABORT
    } state_t;

    localparam int unsigned ENG_MIN_LATENCY = 1;
    localparam int unsigned ENG_MAX_LATENCY = 64;

    // Index width; never below 1 so a vector can always be declared.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rsa_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rsa_rr_arbiter
// Purely combinational round-robin pick: the first asserted request at or
// after the pointer, wrapping. The pointer register lives in the caller.
// Ports:
//   req      in   NUM_REQ   request vector
//   ptr      in   ID_W      highest-priority index this cycle
//   gnt      out  NUM_REQ   one-hot grant (all zero when no request)
//   gnt_idx  out  ID_W      index of the granted request
//   gnt_any  out  1         some request was granted
// ----------------------------------------------------------------------------
module rsa_rr_arbiter
    import rsa_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    int unsigned cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // ptr < NUM_REQ, so one conditional subtract implements the wrap
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!gnt_any && req[cand[ID_W-1:0]]) begin
                gnt_any                = 1'b1;
                gnt[cand[ID_W-1:0]]    = 1'b1;
                gnt_idx                = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rsa_modexp_scheduler.sv
// ----------------------------------------------------------------------------
// rsa_modexp_scheduler
// Shares one modular-exponentiation engine between NUM_REQ requesters.
// Round-robin grant, operand latch, one-cycle engine start, wait for done,
// then hold the result for the winner until it accepts.
// A zero modulus is rejected without starting the engine (rsp_err=1).
//
// Optional feature, macro RSA_SCHED_TIMEOUT_EN: watchdog on S_WAIT. After
// TIMEOUT_CYCLES without eng_done the engine is held in reset for two cycles
// (S_ABORT) and the job is answered with rsp_err=1, rsp_result=0.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            per-requester job handshake (ready is one-hot)
//   req_base/exponent/modulus      packed operands, slice i = requester i
//   rsp_valid/rsp_ready            per-requester response handshake
//   rsp_result, rsp_err            shared response bus, qualified by rsp_valid
//   busy                           scheduler not idle
//   eng_rst_n, eng_start           engine reset (registered) and start pulse
//   eng_base/exponent/modulus      latched operands to the engine
//   eng_result, eng_done           engine result and done pulse
// ----------------------------------------------------------------------------
module rsa_modexp_scheduler
    import rsa_sched_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_base,
    input  logic [NUM_REQ*WIDTH-1:0] req_exponent,
    input  logic [NUM_REQ*WIDTH-1:0] req_modulus,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     eng_rst_n,
    output logic                     eng_start,
    output logic [WIDTH-1:0]         eng_base,
    output logic [WIDTH-1:0]         eng_exponent,
    output logic [WIDTH-1:0]         eng_modulus,
    input  logic [WIDTH-1:0]         eng_result,
    input  logic                     eng_done
);

    localparam int unsigned ID_W = id_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rsa_modexp_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  base_q, base_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic [WIDTH-1:0]  mod_q, mod_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              err_q, err_d;
    logic              rst_dly_q;
    logic              eng_rst_n_q;

`ifdef RSA_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              abort_q, abort_d;   // set in the second S_ABORT cycle
`endif

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic [WIDTH-1:0]   sel_base, sel_exp, sel_mod;

    rsa_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign sel_base = req_base[arb_idx*WIDTH +: WIDTH];
    assign sel_exp  = req_exponent[arb_idx*WIDTH +: WIDTH];
    assign sel_mod  = req_modulus[arb_idx*WIDTH +: WIDTH];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        base_d    = base_q;
        exp_d     = exp_q;
        mod_d     = mod_q;
        result_d  = result_q;
        err_d     = err_q;
        req_ready = '0;
`ifdef RSA_SCHED_TIMEOUT_EN
        cnt_d     = cnt_q;
        abort_d   = abort_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    req_ready = arb_gnt;
                    idx_d     = arb_idx;
                    base_d    = sel_base;
                    exp_d     = sel_exp;
                    mod_d     = sel_mod;
                    ptr_d     = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    if (sel_mod == '0) begin
                        // Rejected job: answer directly, engine untouched
                        state_d  = S_RESP;
                        err_d    = 1'b1;
                        result_d = '0;
                    end else begin
                        state_d  = S_START;
                        err_d    = 1'b0;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef RSA_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                // Done takes priority over the watchdog limit
                if (eng_done) begin
                    result_d = eng_result;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end
`ifdef RSA_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ABORT;
                    abort_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready[idx_q]) begin
                    state_d = S_IDLE;
                end
            end
`ifdef RSA_SCHED_TIMEOUT_EN
            S_ABORT: begin
                if (abort_q) begin
                    state_d  = S_RESP;
                    err_d    = 1'b1;
                    result_d = '0;
                end else begin
                    abort_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            exp_q       <= '0;
            mod_q       <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            rst_dly_q   <= 1'b1;
            eng_rst_n_q <= 1'b0;
`ifdef RSA_SCHED_TIMEOUT_EN
            cnt_q       <= '0;
            abort_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            exp_q       <= exp_d;
            mod_q       <= mod_d;
            result_q    <= result_d;
            err_q       <= err_d;
            rst_dly_q   <= 1'b0;
            // Engine reset trails our own reset by one cycle and covers S_ABORT
            eng_rst_n_q <= !rst_dly_q && (state_d != S_ABORT);
`ifdef RSA_SCHED_TIMEOUT_EN
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
`endif
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign eng_start    = (state_q == S_START);
    assign eng_rst_n    = eng_rst_n_q;
    assign eng_base     = base_q;
    assign eng_exponent = exp_q;
    assign eng_modulus  = mod_q;
    assign rsp_valid    = (state_q == S_RESP) ? (NUM_REQ'(1) << idx_q) : '0;
    assign rsp_err      = (state_q == S_RESP) && err_q;
    assign rsp_result   = result_q;

endmodule

// File: tb/tb_rsa_modexp_scheduler.sv
// ----------------------------------------------------------------------------
// tb_rsa_modexp_scheduler
// Randomised bench for rsa_modexp_scheduler with a behavioural engine stub
// (plain square-and-multiply, random latency, stray done pulses while idle)
// and a round-robin / modexp reference model.
// ----------------------------------------------------------------------------
module tb_rsa_modexp_scheduler;
    import rsa_sched_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned N = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_base, req_exponent, req_modulus;
    logic [W-1:0]   rsp_result, eng_base, eng_exponent, eng_modulus;
    logic [W-1:0]   eng_result = '0;
    logic           eng_done = 1'b0;
    logic           rsp_err, busy, eng_rst_n, eng_start;

    logic [W-1:0] op_base [N];
    logic [W-1:0] op_exp  [N];
    logic [W-1:0] op_mod  [N];

    int n_cmp = 0;
    int n_err = 0;
    int m_ptr = 0;
    int exp_starts = 0;
    int eng_starts = 0;
    int lat_force = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_base[gi*W +: W]     = op_base[gi];
        assign req_exponent[gi*W +: W] = op_exp[gi];
        assign req_modulus[gi*W +: W]  = op_mod[gi];
    end

    rsa_modexp_scheduler #(
        .WIDTH          (W),
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_base     (req_base),
        .req_exponent (req_exponent),
        .req_modulus  (req_modulus),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .eng_rst_n    (eng_rst_n),
        .eng_start    (eng_start),
        .eng_base     (eng_base),
        .eng_exponent (eng_exponent),
        .eng_modulus  (eng_modulus),
        .eng_result   (eng_result),
        .eng_done     (eng_done)
    );

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        logic [63:0] r, x, mm;
        mm = 64'(m);
        r  = 64'(1) % mm;
        x  = 64'(b) % mm;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] pend, input int ptr);
        int c;
        for (int k = 0; k < N; k++) begin
            c = (ptr + k) % N;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ops(input int i);
        int r;
        r = $urandom_range(7, 0);
        op_base[i] = $urandom;
        op_exp[i]  = $urandom;
        op_mod[i]  = (r == 0) ? '0 : (r == 1) ? W'(1) : W'($urandom);
    endtask

    // Engine stub: starts on eng_start, answers after a random latency.
    logic [W-1:0] eng_pending;
    int           eng_cnt = 0;
    bit           eng_busy = 1'b0;

    always @(negedge clk) begin
        eng_done = 1'b0;
        if (eng_rst_n !== 1'b1) begin
            eng_busy = 1'b0;
        end else if (eng_start) begin
            eng_busy    = 1'b1;
            eng_starts++;
            eng_cnt     = (lat_force > 0) ? lat_force : int'($urandom_range(8, ENG_MIN_LATENCY));
            eng_pending = modexp(eng_base, eng_exponent, eng_modulus);
        end else if (eng_busy) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done   = 1'b1;
                eng_result = eng_pending;
                eng_busy   = 1'b0;
            end
        end else if ($urandom_range(9, 0) == 0) begin
            // Stray done with garbage: must be ignored outside S_WAIT
            eng_done   = 1'b1;
            eng_result = $urandom;
        end
    end

    // Serve every requester in mask; the first 'rereq' winners re-request at once.
    task automatic run_round(input logic [N-1:0] mask, input int hold, input int rereq,
                             input bit keep);
        logic [N-1:0] pend;
        logic [W-1:0] er;
        bit           zero;
        int           e, n, rr;
        pend = mask;
        rr   = rereq;
        if (!keep) begin
            for (int i = 0; i < N; i++) if (mask[i]) set_ops(i);
        end
        req_valid = mask;
        #1;
        while (pend != '0) begin
            e = rr_pick(pend, m_ptr);
            n = 0;
            while (req_ready == '0 && n < 50) begin
                step();
                n++;
            end
            check_eq("grant", req_ready, onehot(e));
            if (req_ready !== onehot(e)) begin
                req_valid = '0;
                rsp_ready = '1;
                repeat (100) step();
                rsp_ready = '0;
                return;
            end
            zero = (op_mod[e] == '0);
            er   = zero ? '0 : modexp(op_base[e], op_exp[e], op_mod[e]);
            step();
            pend[e] = 1'b0;
            m_ptr   = (e + 1) % N;
            if (rr > 0) begin
                rr--;
                set_ops(e);
                pend[e] = 1'b1;
            end else begin
                req_valid[e] = 1'b0;
            end
            check_eq("start_pulse", eng_start, !zero);
            if (!zero) exp_starts++;
            n = 0;
            while (rsp_valid == '0 && n < int'(ENG_MAX_LATENCY) + 10) begin
                step();
                n++;
            end
            check_eq("rsp_valid", rsp_valid, onehot(e));
            check_eq("rsp_result", rsp_result, er);
            check_eq("rsp_err", rsp_err, zero);
            for (int h = 0; h < hold; h++) begin
                rsp_ready = N'($urandom) & ~onehot(e);
                step();
                check_eq("hold_valid", rsp_valid, onehot(e));
                check_eq("hold_result", rsp_result, er);
                check_eq("hold_no_grant", req_ready, '0);
            end
            rsp_ready = N'($urandom) | onehot(e);
            step();
            rsp_ready = '0;
            check_eq("rsp_drop", rsp_valid, '0);
        end
    endtask

    initial begin
        int  n;
        bit  saw_rsp;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            op_base[i] = '0;
            op_exp[i]  = '0;
            op_mod[i]  = '0;
        end
        repeat (3) step();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_eng_start", eng_start, 0);
        check_eq("rst_eng_rst_n", eng_rst_n, 0);
        check_eq("rst_result", rsp_result, 0);
        rst = 1'b0;
        step();
        check_eq("rel_eng_rst_n_low", eng_rst_n, 0);
        step();
        check_eq("rel_eng_rst_n_high", eng_rst_n, 1);

        // Contention from reset with req0 re-requesting: order 0,1,0
        run_round(3'b011, 0, 1, 1'b0);

        // Single job with known answer
        op_base[0] = 4;
        op_exp[0]  = 13;
        op_mod[0]  = 497;
        run_round(3'b001, 0, 0, 1'b1);

        // Zero modulus rejected without engine start
        set_ops(1);
        op_mod[1] = '0;
        run_round(3'b010, 0, 0, 1'b1);

        // Response backpressure with a competing request pending
        run_round(3'b011, 10, 0, 1'b0);

        // Reset while the engine is busy
        set_ops(0);
        if (op_mod[0] == '0) op_mod[0] = 497;
        lat_force = 30;
        req_valid = 3'b001;
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin
            step();
            n++;
        end
        check_eq("rmj_grant", req_ready, 3'b001);
        step();
        req_valid = '0;
        exp_starts++;
        check_eq("rmj_start", eng_start, 1);
        repeat (3) step();
        check_eq("rmj_busy_wait", busy, 1);
        rst = 1'b1;
        step();
        check_eq("rmj_busy", busy, 0);
        check_eq("rmj_rsp_valid", rsp_valid, 0);
        check_eq("rmj_rsp_err", rsp_err, 0);
        check_eq("rmj_result", rsp_result, 0);
        check_eq("rmj_eng_start", eng_start, 0);
        check_eq("rmj_eng_mod", eng_modulus, 0);
        check_eq("rmj_eng_rst_n", eng_rst_n, 0);
        rst       = 1'b0;
        m_ptr     = 0;
        lat_force = 0;
        step();
        check_eq("rmj_rel_low", eng_rst_n, 0);
        step();
        check_eq("rmj_rel_high", eng_rst_n, 1);
        saw_rsp = 1'b0;
        repeat (35) begin
            step();
            if (rsp_valid != '0 || busy) saw_rsp = 1'b1;
        end
        check_eq("rmj_silent", saw_rsp, 0);

        // Fresh job after the reset
        set_ops(0);
        if (op_mod[0] == '0) op_mod[0] = 497;
        run_round(3'b001, 0, 0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            run_round(N'($urandom_range(7, 1)), $urandom_range(3, 0), $urandom_range(2, 0),
                      1'b0);
        end

        step();
        check_eq("engine_starts", eng_starts, exp_starts);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
